// File: rtl/roba_pkg.sv
// Shared constants and state type for the ROBA multiplier / dot-product blocks.
package roba_pkg;

  localparam int unsigned ROBA_PW    = 32;
  localparam int unsigned ROBA_AW    = 40;
  localparam int unsigned ROBA_LEN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } roba_state_t;

endpackage

// File: rtl/roba_sat_add.sv
// Combinational AW-bit unsigned saturating adder; sat flags a clamped result.
module roba_sat_add
  import roba_pkg::*;
#(
  parameter int unsigned AW = ROBA_AW
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] sum,
  output logic          sat
);

  logic [AW:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign sat  = full[AW];
  assign sum  = sat ? '1 : full[AW-1:0];

endmodule

// File: rtl/roba_dot_acc.sv
// Saturating reduction stage of the dot-product engine: sums a run of len products.
module roba_dot_acc
  import roba_pkg::*;
#(
  parameter int unsigned PW    = ROBA_PW,
  parameter int unsigned AW    = ROBA_AW,
  parameter int unsigned LEN_W = ROBA_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic [PW-1:0]    p_in,
  input  logic             p_valid,
  output logic             p_ready,
  output logic [AW-1:0]    acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             busy,
  output logic             ovf
);

  roba_state_t      state, state_nx;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    add_sum;
  logic             add_sat;
  logic [LEN_W-1:0] cnt;
  logic             take_start;
  logic             beat;
  logic             last;

  // abort blocks acceptance in the same cycle, so it gates p_ready directly
  assign p_ready    = (state == ST_ACC) && !abort;
  assign beat       = p_ready && p_valid;
  assign last       = beat && (cnt == LEN_W'(1));
  assign take_start = (state == ST_IDLE) && start && !abort;
  assign acc_valid  = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);

  roba_sat_add #(.AW(AW)) u_sat_add (
    .a   (acc),
    .b   (AW'(p_in)),
    .sum (add_sum),
    .sat (add_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (take_start) state_nx = (len == '0) ? ST_DONE : ST_ACC;
      ST_ACC: begin
        if (abort)     state_nx = ST_IDLE;
        else if (last) state_nx = ST_DONE;
      end
      ST_DONE: if (abort || acc_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // acc_out only moves on a completed run, so aborts leave the last result visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      acc_out <= '0;
      ovf     <= 1'b0;
    end else if (take_start) begin
      acc <= '0;
      cnt <= len;
      ovf <= 1'b0;
      if (len == '0) acc_out <= '0;
    end else if (beat) begin
      acc <= add_sum;
      cnt <= cnt - LEN_W'(1);
      if (add_sat) ovf <= 1'b1;
      if (last)    acc_out <= add_sum;
    end
  end

endmodule

// File: tb/tb_roba_dot_acc.sv
// Bench for roba_dot_acc: default-width and AW=33 instances against a run-level sum model.
module tb_roba_dot_acc;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        abort;
  logic [31:0] p_in;
  logic        p_valid;
  logic        acc_ready;

  logic        p_ready_a, acc_valid_a, busy_a, ovf_a;
  logic [39:0] acc_out_a;
  logic        p_ready_b, acc_valid_b, busy_b, ovf_b;
  logic [32:0] acc_out_b;

  int checks = 0;
  int errors = 0;

  roba_dot_acc u_dut40 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready_a),
    .acc_out(acc_out_a), .acc_valid(acc_valid_a), .acc_ready(acc_ready),
    .busy(busy_a), .ovf(ovf_a)
  );

  roba_dot_acc #(.AW(33)) u_dut33 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready_b),
    .acc_out(acc_out_b), .acc_valid(acc_valid_b), .acc_ready(acc_ready),
    .busy(busy_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is just "len products, result = min(total, 2^AW-1)".
  typedef enum {M_IDLE, M_ACC, M_DONE} mode_t;
  mode_t           m_mode;
  int unsigned     m_len, m_beats;
  longint unsigned m_total;
  longint unsigned m_out [2];
  bit              m_ovf [2];
  longint unsigned lim   [2];

  initial begin
    lim[0] = (64'd1 << 40) - 1;
    lim[1] = (64'd1 << 33) - 1;
    m_mode = M_IDLE; m_len = 0; m_beats = 0; m_total = 0;
    for (int unsigned i = 0; i < 2; i++) begin m_out[i] = 0; m_ovf[i] = 0; end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = M_IDLE; m_len = 0; m_beats = 0; m_total = 0;
        for (int unsigned i = 0; i < 2; i++) begin m_out[i] = 0; m_ovf[i] = 0; end
      end else begin
        case (m_mode)
          M_IDLE: if (start && !abort) begin
            m_len = len; m_beats = 0; m_total = 0;
            for (int unsigned i = 0; i < 2; i++) m_ovf[i] = 0;
            if (len == 0) begin
              for (int unsigned i = 0; i < 2; i++) m_out[i] = 0;
              m_mode = M_DONE;
            end else m_mode = M_ACC;
          end
          M_ACC: if (abort) m_mode = M_IDLE;
            else if (p_valid) begin
              m_total += p_in;
              m_beats++;
              for (int unsigned i = 0; i < 2; i++) m_ovf[i] = (m_total > lim[i]);
              if (m_beats == m_len) begin
                for (int unsigned i = 0; i < 2; i++)
                  m_out[i] = (m_total > lim[i]) ? lim[i] : m_total;
                m_mode = M_DONE;
              end
            end
          M_DONE: if (abort || acc_ready) m_mode = M_IDLE;
          default: m_mode = M_IDLE;
        endcase
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("p_ready40",   64'(p_ready_a),   64'(m_mode == M_ACC && !abort));
    check("p_ready33",   64'(p_ready_b),   64'(m_mode == M_ACC && !abort));
    check("acc_valid40", 64'(acc_valid_a), 64'(m_mode == M_DONE));
    check("acc_valid33", 64'(acc_valid_b), 64'(m_mode == M_DONE));
    check("busy40",      64'(busy_a),      64'(m_mode != M_IDLE));
    check("busy33",      64'(busy_b),      64'(m_mode != M_IDLE));
    check("ovf40",       64'(ovf_a),       64'(m_ovf[0]));
    check("ovf33",       64'(ovf_b),       64'(m_ovf[1]));
    if (m_mode != M_ACC) begin
      check("acc_out40", 64'(acc_out_a), m_out[0]);
      check("acc_out33", 64'(acc_out_b), m_out[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int unsigned l);
    start = 1'b1; len = 8'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] v, input int unsigned gap);
    p_valid = 1'b1; p_in = v;
    tick();
    p_valid = 1'b0; p_in = $urandom;
    repeat (gap) tick();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !acc_valid_a; i++) tick();
    check("done_timeout", 64'(acc_valid_a), 64'd1);
  endtask

  task automatic handshake(input int unsigned hold);
    acc_ready = 1'b0;
    repeat (hold) tick();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check("valid_drop", 64'(acc_valid_a), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
    p_in = '0; p_valid = 1'b0; acc_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_p_ready", 64'(p_ready_a), 64'd0);
    check("rst_busy",    64'(busy_a),    64'd0);
    check("rst_valid",   64'(acc_valid_a), 64'd0);
    check("rst_ovf",     64'(ovf_a),     64'd0);
    check("rst_acc_out", 64'(acc_out_a), 64'd0);
    #19 rst_n = 1'b1;
    tick();

    // basic run
    do_start(4);
    for (int unsigned k = 1; k <= 4; k++) beat(32'(k), 0);
    check("basic_valid", 64'(acc_valid_a), 64'd1);
    check("basic_sum",   64'(acc_out_a),   64'd10);
    check("basic_ovf",   64'(ovf_a),       64'd0);
    handshake(0);
    check("basic_idle",  64'(busy_a),      64'd0);

    // gaps and backpressure
    do_start(3);
    beat(32'h0000FFFF, 2);
    beat(32'h00010000, 2);
    beat(32'h7, 0);
    wait_done();
    repeat (5) begin
      check("hold_sum", 64'(acc_out_a), 64'h20006);
      tick();
    end
    handshake(0);

    // saturation in the 33-bit instance only
    do_start(3);
    repeat (3) beat(32'hFFFFFFFF, 0);
    check("sat33_sum", 64'(acc_out_b), 64'h1FFFFFFFF);
    check("sat33_ovf", 64'(ovf_b),     64'd1);
    check("sat40_sum", 64'(acc_out_a), 64'h2FFFFFFFD);
    check("sat40_ovf", 64'(ovf_a),     64'd0);
    handshake(2);
    check("sat33_ovf_idle", 64'(ovf_b), 64'd1);
    do_start(2);
    beat(32'd1, 0); beat(32'd1, 0);
    check("resat_sum", 64'(acc_out_b), 64'd2);
    check("resat_ovf", 64'(ovf_b),     64'd0);
    handshake(1);

    // zero length, with p_valid held to show nothing is accepted
    p_valid = 1'b1;
    do_start(0);
    check("zero_valid", 64'(acc_valid_a), 64'd1);
    check("zero_sum",   64'(acc_out_a),   64'd0);
    check("zero_ready", 64'(p_ready_a),   64'd0);
    p_valid = 1'b0;
    handshake(1);

    // abort after two beats, product offered in the abort cycle
    do_start(5);
    beat(32'd3, 0); beat(32'd4, 0);
    abort = 1'b1; p_valid = 1'b1; p_in = 32'd100;
    #1 check("abort_ready", 64'(p_ready_a), 64'd0);
    tick();
    abort = 1'b0; p_valid = 1'b0;
    check("abort_busy",  64'(busy_a),      64'd0);
    check("abort_valid", 64'(acc_valid_a), 64'd0);
    repeat (2) tick();

    // start while in ACC is ignored
    do_start(2);
    beat(32'd5, 0);
    start = 1'b1; len = 8'd7;
    beat(32'd6, 0);
    start = 1'b0;
    check("ign_valid", 64'(acc_valid_a), 64'd1);
    check("ign_sum",   64'(acc_out_a),   64'd11);
    handshake(0);

    // asynchronous reset mid-run with ovf set on the 33-bit instance
    do_start(4);
    repeat (3) beat(32'hFFFFFFFF, 0);
    check("pre_rst_ovf33", 64'(ovf_b), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_p_ready", 64'(p_ready_b),   64'd0);
    check("arst_busy",    64'(busy_b),      64'd0);
    check("arst_valid",   64'(acc_valid_b), 64'd0);
    check("arst_ovf",     64'(ovf_b),       64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    do_start(1);
    beat(32'd9, 0);
    check("post_rst_sum", 64'(acc_out_a), 64'd9);
    handshake(0);

    // randomized traffic, checked every cycle by the model
    repeat (3000) begin
      start     = ($urandom_range(7) == 0);
      len       = ($urandom_range(5) == 0) ? 8'd0 : 8'($urandom_range(10, 1));
      abort     = ($urandom_range(39) == 0);
      p_valid   = ($urandom_range(2) != 0);
      p_in      = ($urandom_range(3) == 0) ? 32'hFFFFFFFF : $urandom;
      acc_ready = ($urandom_range(2) == 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; p_valid = 1'b0; acc_ready = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
